if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of the decode stage. Owns the program counter, issues word fetches to a variable-latency instruction memory over a req/ack handshake, buffers fetched words with their PC+4 in a small FIFO, and presents them to decode under a freeze (stall) signal. Taken branches redirect the PC, flush buffered words and discard any in-flight fetch.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_stage_if.sv | 24 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// Fetch FSM encoding, word width and the fetch-buffer entry layout.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef logic [1:0] fstate_t;

    localparam fstate_t S_IDLE = 2'd0;
    localparam fstate_t S_WAIT = 2'd1;
    localparam fstate_t S_DROP = 2'd2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage and imem.
// The fetch stage is the master; memory answers with ack and data.
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched words with their PC+4.
// Flush wins over push/pop; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one outstanding imem fetch, fetch buffer.
// Taken branches flush the buffer and discard any in-flight fetch.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    if_stage_if.master         imem,
    input  logic               freeze,
    input  logic               br_taken,
    input  logic [31:0]        br_addr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fstate_t       state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_q, req_d;
    logic [31:0]   pc_inc;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_after;
    logic          ack_wait;
    logic          push;
    logic          pop;
    fetch_t        head;
    fetch_t        entry;

    assign pc_inc    = pc_q + PC_INC;
    assign ack_wait  = (state_q == S_WAIT) && imem.imem_ack;
    assign push      = ack_wait && !br_taken;
    assign pop       = if_valid && !freeze && !br_taken;
    assign cnt_after = count + CW'(push) - CW'(pop);
    assign entry     = '{instr: imem.imem_rdata, pc: pc_inc};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        if (br_taken) begin
            pc_d = br_addr;
            // An unacked fetch must still complete before a new request.
            if (state_q != S_IDLE && !imem.imem_ack) state_d = S_DROP;
            else                                     state_d = S_IDLE;
        end else begin
            unique case (1'b1)
                state_q == S_IDLE: begin
                    if (count < DEPTH_C) begin
                        state_d = S_WAIT;
                        req_d   = pc_q;
                    end
                end
                state_q == S_WAIT: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_inc;
                        if (cnt_after < DEPTH_C) req_d = pc_inc;
                        else                     state_d = S_IDLE;
                    end
                end
                state_q == S_DROP: begin
                    if (imem.imem_ack) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (br_taken),
        .data_i  (entry),
        .data_o  (head),
        .count_o (count)
    );

    assign imem.imem_req  = (state_q != S_IDLE);
    assign imem.imem_addr = req_q;
    assign if_valid       = (count != '0);
    assign if_instr       = if_valid ? head.instr : '0;
    assign if_pc          = if_valid ? head.pc : '0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random freeze/branch
// traffic checked against an in-order program-counter stream model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    if_stage_if bus();

    int lat = 0;
    int mcnt = 0;

    always #5 clk = ~clk;

    // Memory: acks after lat extra cycles, data is a function of address.
    assign bus.imem_ack   = bus.imem_req && (mcnt >= lat);
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA000_0000;

    always @(posedge clk)
        mcnt <= (!bus.imem_req || bus.imem_ack) ? 0 : mcnt + 1;

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (bus),
        .freeze   (freeze),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc)
    );

    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          pops = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        found;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode sees the program in order from the last redirect target.
    task automatic model_check();
        if (!if_valid) begin
            chk("empty_instr", if_instr, 32'h0);
            chk("empty_pc", if_pc, 32'h0);
        end else begin
            chk("head_pc", if_pc, exp_pc + 32'd4);
            chk("head_instr", if_instr, f(exp_pc));
        end
        if (if_valid && !freeze && !br_taken) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (br_taken) exp_pc = br_addr;
        if (pend && bus.imem_req)
            chk("addr_stable", bus.imem_addr, pend_addr);
        pend      = bus.imem_req && !bus.imem_ack;
        pend_addr = bus.imem_addr;
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        freeze   = 1'b0;
        br_taken = 1'b0;
        #1;
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        exp_pc = 32'h0;
        pend   = 1'b0;
    endtask

    initial begin
        #1;
        lat = 0;
        do_reset();

        // zero-wait streaming
        tick();
        chk("c1_req", {31'h0, bus.imem_req}, 32'h1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        tick();
        chk("c2_valid", {31'h0, if_valid}, 32'h1);
        chk("c2_instr", if_instr, 32'hA000_0000);
        chk("c2_pc", if_pc, 32'h4);
        tick();
        chk("c3_instr", if_instr, 32'hA000_0004);
        chk("c3_pc", if_pc, 32'h8);
        repeat (4) begin
            tick();
            chk("stream_valid", {31'h0, if_valid}, 32'h1);
        end

        // freeze fills the buffer and stops requests
        freeze = 1'b1;
        repeat (5) tick();
        chk("frz_req", {31'h0, bus.imem_req}, 32'h0);
        chk("frz_valid", {31'h0, if_valid}, 32'h1);
        freeze = 1'b0;
        repeat (8) tick();

        // redirect while a slow fetch is outstanding
        lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = bus.imem_req && (bus.imem_addr == 32'h8);
        end
        chk("saw_req8", {31'h0, found}, 32'h1);
        tick();
        br_taken = 1'b1;
        br_addr  = 32'h100;
        tick();
        br_taken = 1'b0;
        chk("drop_req", {31'h0, bus.imem_req}, 32'h1);
        chk("drop_addr", bus.imem_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.imem_req && (bus.imem_addr == 32'h100);
        end
        chk("redir_req", {31'h0, found}, 32'h1);
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        chk("redir_pc", if_pc, 32'h104);

        // redirect coincident with ack, buffer filling, decode frozen
        lat = 1;
        do_reset();
        freeze = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = bus.imem_ack && if_valid;
        end
        chk("ack_full", {31'h0, found}, 32'h1);
        br_taken = 1'b1;
        br_addr  = 32'h100;
        tick();
        br_taken = 1'b0;
        chk("flush_valid", {31'h0, if_valid}, 32'h0);
        chk("flush_instr", if_instr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.imem_req && (bus.imem_addr == 32'h100);
        end
        chk("flush_refetch", {31'h0, found}, 32'h1);
        freeze = 1'b0;
        repeat (6) tick();

        // PC wrap
        lat      = 0;
        br_taken = 1'b1;
        br_addr  = 32'hFFFF_FFF8;
        tick();
        br_taken = 1'b0;
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_in0", if_instr, 32'h5FFF_FFF8);
        tick();
        chk("wrap_pc1", if_pc, 32'h0);
        chk("wrap_in1", if_instr, 32'h5FFF_FFFC);
        tick();
        chk("wrap_pc2", if_pc, 32'h4);
        chk("wrap_in2", if_instr, 32'hA000_0000);

        // async reset in the middle of a fetch
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.imem_req && !bus.imem_ack;
        end
        chk("mid_fetch", {31'h0, found}, 32'h1);
        #3;
        do_reset();
        tick();
        chk("restart_req", {31'h0, bus.imem_req}, 32'h1);
        chk("restart_addr", bus.imem_addr, 32'h0);

        // random traffic against the stream model
        for (int s = 0; s < 4; s++) begin
            lat = int'($urandom_range(0, 3));
            do_reset();
            for (int i = 0; i < 150; i++) begin
                freeze   = ($urandom % 10) < 3;
                br_taken = ($urandom % 20) == 0;
                br_addr  = $urandom & 32'hFFFF_FFFC;
                tick();
            end
            freeze   = 1'b0;
            br_taken = 1'b0;
            repeat (10) tick();
        end
        chk("progress", {31'h0, pops > 50}, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
